// File: rtl/cnn_ctrl_pkg.sv
// Shared types and constants for the binary-CNN sequencer.
// Memory strobes are active-low; STB_ON/STB_OFF name the two levels.
package cnn_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_K,
    S_LD_W,
    S_READY,
    S_CLS,
    S_DRAIN
  } state_t;

  localparam logic STB_ON  = 1'b0;
  localparam logic STB_OFF = 1'b1;

  localparam int NWIN_MAX = 4;

  typedef logic [$clog2(NWIN_MAX)-1:0] win_cnt_t;

endpackage

// File: rtl/mem_rd_seq.sv
// Dual-port memory read sequencer: streams address pairs on start,
// then raises a load strobe with the pair index one cycle later.
import cnn_ctrl_pkg::*;

module mem_rd_seq #(
  parameter int ADDR_W = 5,
  parameter int NUM    = 2,
  parameter int BASE   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] add1,
  output logic [ADDR_W-1:0] add2,
  output logic              csb1,
  output logic              csb2,
  output logic              oeb1,
  output logic              oeb2,
  output logic              load,
  output logic [2:0]        idx,
  output logic              done
);

  localparam int PAIRS = NUM / 2;
  localparam int CW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;

  logic          rd;
  logic          stb;
  logic [CW-1:0] cnt;
  logic          last;

  assign last = rd && (cnt == CW'(PAIRS - 1));
  assign done = last;

  assign csb1 = stb;
  assign csb2 = stb;
  assign oeb1 = stb;
  assign oeb2 = stb;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd   <= 1'b0;
      cnt  <= '0;
      stb  <= STB_OFF;
      add1 <= '0;
      add2 <= '0;
      load <= 1'b0;
      idx  <= '0;
    end else begin
      // read data lands one cycle after its address
      load <= rd;
      idx  <= rd ? 3'(cnt) : 3'd0;
      if (rd) begin
        if (last) begin
          rd   <= 1'b0;
          cnt  <= '0;
          stb  <= STB_OFF;
          add1 <= '0;
          add2 <= '0;
        end else begin
          cnt  <= cnt + 1'b1;
          add1 <= add1 + ADDR_W'(2);
          add2 <= add2 + ADDR_W'(2);
        end
      end else if (start) begin
        rd   <= 1'b1;
        cnt  <= '0;
        stb  <= STB_ON;
        add1 <= ADDR_W'(BASE);
        add2 <= ADDR_W'(BASE + 1);
      end
    end
  end

endmodule

// File: rtl/cnn_seq_ctrl.sv
// Sequencer for the binary-CNN datapath: kernel/weight load from
// KMEM/WMEM, then window pacing into the MAC and result flagging.
import cnn_ctrl_pkg::*;

module cnn_seq_ctrl #(
  parameter int ADDR_W = 5,
  parameter int NUM_K  = 2,
  parameter int NUM_W  = 4,
  parameter int K_BASE = 0,
  parameter int W_BASE = 0,
  parameter int NWIN   = 4,
  parameter int DRAIN  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              learn,
  input  logic              classify,
  output logic [ADDR_W-1:0] kmem_add1,
  output logic [ADDR_W-1:0] kmem_add2,
  output logic              kmem_csb1,
  output logic              kmem_csb2,
  output logic              kmem_oeb1,
  output logic              kmem_oeb2,
  output logic              kmem_web1,
  output logic              kmem_web2,
  output logic [ADDR_W-1:0] wmem_add1,
  output logic [ADDR_W-1:0] wmem_add2,
  output logic              wmem_csb1,
  output logic              wmem_csb2,
  output logic              wmem_oeb1,
  output logic              wmem_oeb2,
  output logic              wmem_web1,
  output logic              wmem_web2,
  output logic              k_load,
  output logic              w_load,
  output logic [2:0]        load_idx,
  input  logic              win_valid,
  output logic              win_ready,
  output logic [1:0]        win_idx,
  output logic              mac_en,
  output logic              mac_clr,
  output logic              res_valid,
  output logic              loaded,
  output logic              busy,
  output logic              cls_err
);

  localparam int DW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

  state_t        state;
  state_t        nxt;
  logic          k_start;
  logic          w_start;
  logic          k_done;
  logic          w_done;
  logic [2:0]    k_idx;
  logic [2:0]    w_idx;
  win_cnt_t      beat_cnt;
  logic [DW-1:0] drn_cnt;
  logic          beat;
  logic          last_beat;
  logic          drn_last;

  logic          win_ready_nx;
  logic [1:0]    win_idx_nx;
  logic          mac_en_nx;
  logic          mac_clr_nx;
  logic          res_valid_nx;
  logic          loaded_nx;
  logic          busy_nx;
  logic          cls_err_nx;

  assign kmem_web1 = STB_OFF;
  assign kmem_web2 = STB_OFF;
  assign wmem_web1 = STB_OFF;
  assign wmem_web2 = STB_OFF;

  // k_load and w_load never coincide; idle sequencers drive idx=0
  assign load_idx = k_idx | w_idx;

  mem_rd_seq #(
    .ADDR_W (ADDR_W),
    .NUM    (NUM_K),
    .BASE   (K_BASE)
  ) u_kseq (
    .clk   (clk),
    .rst   (rst),
    .start (k_start),
    .add1  (kmem_add1),
    .add2  (kmem_add2),
    .csb1  (kmem_csb1),
    .csb2  (kmem_csb2),
    .oeb1  (kmem_oeb1),
    .oeb2  (kmem_oeb2),
    .load  (k_load),
    .idx   (k_idx),
    .done  (k_done)
  );

  mem_rd_seq #(
    .ADDR_W (ADDR_W),
    .NUM    (NUM_W),
    .BASE   (W_BASE)
  ) u_wseq (
    .clk   (clk),
    .rst   (rst),
    .start (w_start),
    .add1  (wmem_add1),
    .add2  (wmem_add2),
    .csb1  (wmem_csb1),
    .csb2  (wmem_csb2),
    .oeb1  (wmem_oeb1),
    .oeb2  (wmem_oeb2),
    .load  (w_load),
    .idx   (w_idx),
    .done  (w_done)
  );

  assign beat      = (state == S_CLS) && win_valid && win_ready;
  assign last_beat = beat && (beat_cnt == win_cnt_t'(NWIN - 1));
  assign drn_last  = (state == S_DRAIN) && (drn_cnt == DW'(DRAIN - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt     = state;
    k_start = 1'b0;
    w_start = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (learn) begin
          nxt     = S_LD_K;
          k_start = 1'b1;
        end
      end
      S_LD_K: begin
        // weight reads overlap the final kernel load strobe
        if (k_done) begin
          nxt     = S_LD_W;
          w_start = 1'b1;
        end
      end
      S_LD_W: begin
        if (w_done) nxt = S_READY;
      end
      S_READY: begin
        if (learn) begin
          nxt     = S_LD_K;
          k_start = 1'b1;
        end else if (classify) begin
          nxt = S_CLS;
        end
      end
      S_CLS: begin
        if (last_beat) nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (drn_last) nxt = classify ? S_CLS : S_READY;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    win_ready_nx = (nxt == S_CLS);
    mac_en_nx    = beat;
    mac_clr_nx   = beat && (beat_cnt == '0);
    win_idx_nx   = beat ? 2'(beat_cnt) : 2'd0;
    res_valid_nx = drn_last;
    cls_err_nx   = (state == S_IDLE) && classify && !learn;
    busy_nx      = !((nxt == S_IDLE) || (nxt == S_READY));
    loaded_nx    = loaded;
    if ((state == S_LD_W) && w_done) loaded_nx = 1'b1;
    if (k_start)                     loaded_nx = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_ready <= 1'b0;
      win_idx   <= '0;
      mac_en    <= 1'b0;
      mac_clr   <= 1'b0;
      res_valid <= 1'b0;
      loaded    <= 1'b0;
      busy      <= 1'b0;
      cls_err   <= 1'b0;
    end else begin
      win_ready <= win_ready_nx;
      win_idx   <= win_idx_nx;
      mac_en    <= mac_en_nx;
      mac_clr   <= mac_clr_nx;
      res_valid <= res_valid_nx;
      loaded    <= loaded_nx;
      busy      <= busy_nx;
      cls_err   <= cls_err_nx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_cnt <= '0;
      drn_cnt  <= '0;
    end else begin
      if (state != S_CLS)  beat_cnt <= '0;
      else if (last_beat)  beat_cnt <= '0;
      else if (beat)       beat_cnt <= beat_cnt + 1'b1;
      if (state != S_DRAIN) drn_cnt <= '0;
      else if (drn_last)    drn_cnt <= '0;
      else                  drn_cnt <= drn_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_cnn_seq_ctrl.sv
// Self-checking bench for cnn_seq_ctrl: load sequence table checks
// plus a timed scoreboard of MAC beats and result pulses.
module tb_cnn_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       learn = 1'b0;
  logic       classify = 1'b0;
  logic       win_valid = 1'b0;
  logic [4:0] kmem_add1, kmem_add2, wmem_add1, wmem_add2;
  logic       kmem_csb1, kmem_csb2, kmem_oeb1, kmem_oeb2;
  logic       kmem_web1, kmem_web2;
  logic       wmem_csb1, wmem_csb2, wmem_oeb1, wmem_oeb2;
  logic       wmem_web1, wmem_web2;
  logic       k_load, w_load;
  logic [2:0] load_idx;
  logic       win_ready;
  logic [1:0] win_idx;
  logic       mac_en, mac_clr, res_valid;
  logic       loaded, busy, cls_err;

  cnn_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .learn     (learn),
    .classify  (classify),
    .kmem_add1 (kmem_add1),
    .kmem_add2 (kmem_add2),
    .kmem_csb1 (kmem_csb1),
    .kmem_csb2 (kmem_csb2),
    .kmem_oeb1 (kmem_oeb1),
    .kmem_oeb2 (kmem_oeb2),
    .kmem_web1 (kmem_web1),
    .kmem_web2 (kmem_web2),
    .wmem_add1 (wmem_add1),
    .wmem_add2 (wmem_add2),
    .wmem_csb1 (wmem_csb1),
    .wmem_csb2 (wmem_csb2),
    .wmem_oeb1 (wmem_oeb1),
    .wmem_oeb2 (wmem_oeb2),
    .wmem_web1 (wmem_web1),
    .wmem_web2 (wmem_web2),
    .k_load    (k_load),
    .w_load    (w_load),
    .load_idx  (load_idx),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_idx   (win_idx),
    .mac_en    (mac_en),
    .mac_clr   (mac_clr),
    .res_valid (res_valid),
    .loaded    (loaded),
    .busy      (busy),
    .cls_err   (cls_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         c;
    logic [1:0] idx;
    logic       clr;
  } beat_t;

  beat_t       bq[$];
  int          rq[$];
  beat_t       bh;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          res_n = 0;
  int          cls_n = 0;
  int          e0 = 0;
  int          rtmp = 0;
  logic [18:0] st;
  logic [18:0] lst [5];
  int          pat [7];

  always @(posedge clk) cyc <= cyc + 1;

  assign st = {kmem_csb1, kmem_csb2, kmem_oeb1, kmem_oeb2,
               wmem_csb1, wmem_csb2, wmem_oeb1, wmem_oeb2,
               kmem_web1, kmem_web2, wmem_web1, wmem_web2,
               k_load, w_load, load_idx, loaded, busy};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [18:0] mk(input logic ks, input logic ws,
                                     input logic kl, input logic wl,
                                     input logic [2:0] idx,
                                     input logic ld, input logic bz);
    return {{4{ks}}, {4{ws}}, 4'b1111, kl, wl, idx, ld, bz};
  endfunction

  task automatic drain(input int lim);
    for (int i = 0; i < lim && (bq.size() > 0 || rq.size() > 0); i++)
      @(negedge clk);
  endtask

  task automatic push_img(input int base);
    for (int k = 0; k < 4; k++)
      bq.push_back('{base + 1 + k, k[1:0], k == 0});
    rq.push_back(base + 6);
  endtask

  // scoreboard: pops timed expectations when the DUT produces output
  always @(negedge clk) begin
    if (rst) begin
      if (mac_en) begin
        if (bq.size() == 0) begin
          chk("mac_extra", 32'(mac_en), 32'd0);
        end else begin
          bh = bq.pop_front();
          chk("mac_cyc", cyc, bh.c);
          chk("win_idx", 32'(win_idx), 32'(bh.idx));
          chk("mac_clr", 32'(mac_clr), 32'(bh.clr));
        end
      end else if (bq.size() > 0 && cyc >= bq[0].c) begin
        void'(bq.pop_front());
        chk("mac_miss", 32'(mac_en), 32'd1);
      end
      if (res_valid) begin
        res_n++;
        if (rq.size() == 0) begin
          chk("res_extra", 32'(res_valid), 32'd0);
        end else begin
          rtmp = rq.pop_front();
          chk("res_cyc", cyc, rtmp);
        end
      end else if (rq.size() > 0 && cyc >= rq[0]) begin
        void'(rq.pop_front());
        chk("res_miss", 32'(res_valid), 32'd1);
      end
      if (cls_err) cls_n++;
    end
  end

  initial begin
    lst[0] = mk(0, 1, 0, 0, 3'd0, 0, 1);
    lst[1] = mk(1, 0, 1, 0, 3'd0, 0, 1);
    lst[2] = mk(1, 0, 0, 1, 3'd0, 0, 1);
    lst[3] = mk(1, 1, 0, 1, 3'd1, 1, 0);
    lst[4] = mk(1, 1, 0, 0, 3'd0, 1, 0);
    pat = '{1, 1, 0, 0, 0, 1, 1};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_st", st, mk(1, 1, 0, 0, 3'd0, 0, 0));
    chk("rst_out", {26'd0, win_ready, win_idx, mac_en, mac_clr,
                    res_valid | cls_err}, 32'd0);
    chk("rst_add", {kmem_add1, kmem_add2, wmem_add1, wmem_add2}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // classify before any learn is rejected
    classify = 1'b1;
    @(posedge clk);
    #1;
    classify = 1'b0;
    @(negedge clk);
    chk("cls_err_on", 32'(cls_err), 32'd1);
    chk("cls_idle", st, mk(1, 1, 0, 0, 3'd0, 0, 0));
    @(negedge clk);
    chk("cls_err_off", 32'(cls_err), 32'd0);

    // learn sequence, cycle by cycle
    @(posedge clk);
    #1;
    learn = 1'b1;
    @(posedge clk);
    #1;
    learn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("ld_st%0d", i), st, lst[i]);
      if (i == 0)
        chk("k_add", {kmem_add1, kmem_add2}, 32'h0001);
      if (i == 1 || i == 2)
        chk($sformatf("w_add%0d", i), {wmem_add1, wmem_add2},
            32'(((2 * (i - 1)) << 5) | (2 * (i - 1) + 1)));
    end

    // four back-to-back images, no stalls
    @(posedge clk);
    #1;
    classify = 1'b1;
    win_valid = 1'b1;
    e0 = cyc + 1;
    for (int m = 0; m < 4; m++) push_img(e0 + 6 * m);
    repeat (24) @(posedge clk);
    #1;
    classify = 1'b0;
    drain(40);
    @(negedge clk);
    chk("res_cnt4", res_n, 4);
    chk("ready_st", {29'd0, win_ready, loaded, busy}, 32'd2);

    // one image with a 3-cycle stall after beat 1
    @(posedge clk);
    #1;
    classify = 1'b1;
    e0 = cyc + 1;
    bq.push_back('{e0 + 1, 2'd0, 1'b1});
    bq.push_back('{e0 + 2, 2'd1, 1'b0});
    bq.push_back('{e0 + 6, 2'd2, 1'b0});
    bq.push_back('{e0 + 7, 2'd3, 1'b0});
    rq.push_back(e0 + 9);
    @(posedge clk);
    #1;
    classify = 1'b0;
    for (int j = 0; j < 7; j++) begin
      win_valid = pat[j][0];
      @(posedge clk);
      #1;
    end
    win_valid = 1'b1;
    drain(30);
    chk("res_cnt5", res_n, 5);

    // learn and classify together in READY: reload wins
    @(posedge clk);
    #1;
    learn = 1'b1;
    classify = 1'b1;
    @(posedge clk);
    #1;
    learn = 1'b0;
    classify = 1'b0;
    @(negedge clk);
    chk("rl_loaded", 32'(loaded), 32'd0);
    chk("rl_busy", 32'(busy), 32'd1);
    chk("rl_kcsb", 32'(kmem_csb1), 32'd0);

    // asynchronous reset in the middle of the weight load
    @(posedge clk);
    #1;
    chk("pre_rst_w", 32'(wmem_csb1), 32'd0);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_st", st, mk(1, 1, 0, 0, 3'd0, 0, 0));
    chk("arst_out", {27'd0, win_ready, mac_en, res_valid, cls_err, busy},
        32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("post_rst%0d", i), st, mk(1, 1, 0, 0, 3'd0, 0, 0));
    end

    // recovery: learn again and classify a single image
    @(posedge clk);
    #1;
    learn = 1'b1;
    @(posedge clk);
    #1;
    learn = 1'b0;
    for (int i = 0; i < 20 && !loaded; i++) @(negedge clk);
    chk("relearn", 32'(loaded), 32'd1);
    @(posedge clk);
    #1;
    classify = 1'b1;
    e0 = cyc + 1;
    push_img(e0);
    @(posedge clk);
    #1;
    classify = 1'b0;
    drain(30);
    repeat (3) @(negedge clk);

    chk("cls_cnt", cls_n, 1);
    chk("res_total", res_n, 6);
    chk("bq_left", bq.size(), 0);
    chk("rq_left", rq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
